// File: rtl/rom_arbiter.sv
// Two-port req/gnt/rvalid front end for the single-port boot ROM.
// Round-robin arbitration, range/alignment/write checking and a one-deep response stage.
module rom_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 32'h0010_0000,
    parameter logic [ADDR_WIDTH-1:0] ROM_SIZE   = 32'h0000_0600
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic                  rom_req_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    // One extra bit so a ROM that ends at the top of the address space does not wrap.
    localparam logic [ADDR_WIDTH:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [ADDR_WIDTH:0] ROM_HI = ROM_LO + {1'b0, ROM_SIZE};

    port_e                 r_last;
    logic                  r_rsp_valid;
    port_e                 r_rsp_port;
    logic                  r_rsp_err;

    logic                  w_instr_gnt;
    logic                  w_data_gnt;
    logic                  w_any_gnt;
    port_e                 w_sel_port;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_we;
    logic [ADDR_WIDTH:0]   w_addr_ext;
    logic                  w_legal;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_instr_gnt = 1'b0;
        w_data_gnt  = 1'b0;
        if (!rst_i) begin
            if (instr_req_i && (!data_req_i || r_last == PORT_DATA)) begin
                w_instr_gnt = 1'b1;
            end else if (data_req_i) begin
                w_data_gnt = 1'b1;
            end
        end

        w_any_gnt  = w_instr_gnt | w_data_gnt;
        w_sel_port = w_data_gnt ? PORT_DATA : PORT_INSTR;
        w_sel_addr = w_data_gnt ? data_addr_i : instr_addr_i;
        w_sel_we   = w_data_gnt & data_we_i;
        w_addr_ext = {1'b0, w_sel_addr};
        w_legal    = (w_addr_ext >= ROM_LO) && (w_addr_ext < ROM_HI)
                     && (w_sel_addr[1:0] == 2'b00) && !w_sel_we;
    end

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;
    assign rom_req_o   = w_any_gnt & w_legal;
    assign rom_addr_o  = (w_any_gnt && w_legal) ? w_sel_addr : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last      <= PORT_DATA;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= PORT_INSTR;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_last     <= w_sel_port;
                r_rsp_port <= w_sel_port;
                r_rsp_err  <= ~w_legal;
            end
        end
    end

    // ROM data is only forwarded for legal accesses; errors return zero data.
    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_err_o    = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_err_o     = 1'b0;
        data_rdata_o   = '0;
        if (r_rsp_valid) begin
            if (r_rsp_port == PORT_INSTR) begin
                instr_rvalid_o = 1'b1;
                instr_err_o    = r_rsp_err;
                instr_rdata_o  = r_rsp_err ? '0 : rom_rdata_i;
            end else begin
                data_rvalid_o = 1'b1;
                data_err_o    = r_rsp_err;
                data_rdata_o  = r_rsp_err ? '0 : rom_rdata_i;
            end
        end
    end

endmodule
